// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, error cause codes, default timeout.
// Odd-parity enforcement is controlled by the PS2_PARITY_CHECK_EN macro in the read module.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } ps2State_t;

    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // 2 ms at 50 MHz without a PS2_CLK falling edge aborts a frame.
    localparam logic [16:0] T_TIMEOUT_DEF = 17'd100000;

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus falling-edge detect.
// isH2L is high for one CLOCK cycle, two cycles after the pin clock falls.
module ps2_edge_sync (
    input  logic CLOCK,
    input  logic RESET,
    input  logic PS2_CLK,
    input  logic PS2_DAT,
    output logic isH2L,
    output logic datSync
);

    // clkSync[1:0] is the synchronizer, clkSync[2] the previous synced value.
    logic [2:0] clkSync;
    logic [1:0] datPipe;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            clkSync <= 3'b111;
            datPipe <= 2'b11;
        end else begin
            clkSync <= {clkSync[1:0], PS2_CLK};
            datPipe <= {datPipe[0], PS2_DAT};
        end
    end

    assign isH2L   = clkSync[2] & ~clkSync[1];
    assign datSync = datPipe[1];

endmodule

// File: rtl/ps2_read_funcmod.sv
// PS/2 host receive engine: start/8 data/parity/stop frame capture with timeout abort.
// Define PS2_PARITY_CHECK_EN to enforce odd parity; otherwise the parity bit is discarded.
module ps2_read_funcmod
    import ps2_pkg::*;
#(
    parameter logic [16:0] T_TIMEOUT = T_TIMEOUT_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       iEn,
    output logic [7:0] oData,
    output logic       oTrig,
    output logic       oErr,
    output logic [1:0] oErrCode
);

    logic        isH2L;
    logic        datSync;
    ps2State_t   state;
    ps2State_t   nextState;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftReg;
    logic [16:0] toCnt;
    logic        timedOut;
    logic        parityOk;
    logic [7:0]  dataNext;
    logic        trigNext;
    logic        errNext;
    logic [1:0]  codeNext;

    ps2_edge_sync uSync (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .isH2L   (isH2L),
        .datSync (datSync)
    );

    // A falling edge in the same cycle as the timeout wins: the bus is still alive.
    assign timedOut = (toCnt == T_TIMEOUT - 17'd1) && !isH2L;

`ifdef PS2_PARITY_CHECK_EN
    logic parBit;
    assign parityOk = ^{shiftReg, parBit};
`else
    assign parityOk = 1'b1;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (!iEn) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (isH2L && !datSync) nextState = DATA;
                DATA:    if (timedOut) nextState = IDLE;
                         else if (isH2L && bitCnt == 3'd7) nextState = PARITY;
                PARITY:  if (timedOut) nextState = IDLE;
                         else if (isH2L) nextState = STOP;
                STOP:    if (timedOut) nextState = IDLE;
                         else if (isH2L) nextState = datSync ? DONE : IDLE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // The frame verdict is taken on the stop edge so results are visible during DONE.
    always_comb begin
        dataNext = oData;
        trigNext = 1'b0;
        errNext  = 1'b0;
        codeNext = oErrCode;
        if (iEn) begin
            case (state)
                DATA, PARITY: begin
                    if (timedOut) begin
                        errNext  = 1'b1;
                        codeNext = ERR_TIMEOUT;
                    end
                end
                STOP: begin
                    if (isH2L) begin
                        if (!datSync) begin
                            errNext  = 1'b1;
                            codeNext = ERR_FRAME;
                        end else if (parityOk) begin
                            trigNext = 1'b1;
                            dataNext = shiftReg;
                        end else begin
                            errNext  = 1'b1;
                            codeNext = ERR_PARITY;
                        end
                    end else if (timedOut) begin
                        errNext  = 1'b1;
                        codeNext = ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            oData    <= 8'h00;
            oTrig    <= 1'b0;
            oErr     <= 1'b0;
            oErrCode <= 2'b00;
        end else begin
            oData    <= dataNext;
            oTrig    <= trigNext;
            oErr     <= errNext;
            oErrCode <= codeNext;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
            toCnt    <= 17'd0;
`ifdef PS2_PARITY_CHECK_EN
            parBit   <= 1'b0;
`endif
        end else begin
            case (state)
                DATA: begin
                    if (isH2L) begin
                        shiftReg[bitCnt] <= datSync;
                        bitCnt           <= bitCnt + 3'd1;
                        toCnt            <= 17'd0;
                    end else begin
                        toCnt <= toCnt + 17'd1;
                    end
                end
                PARITY: begin
                    if (isH2L) begin
`ifdef PS2_PARITY_CHECK_EN
                        parBit <= datSync;
`endif
                        toCnt  <= 17'd0;
                    end else begin
                        toCnt <= toCnt + 17'd1;
                    end
                end
                STOP: begin
                    if (isH2L) toCnt <= 17'd0;
                    else       toCnt <= toCnt + 17'd1;
                end
                default: begin
                    bitCnt <= 3'd0;
                    toCnt  <= 17'd0;
                end
            endcase
        end
    end

endmodule
